// File: rtl/mux_fdbk_src_tx_if.sv
`default_nettype none
// ============================================================================
// mux_fdbk_src_tx_if : upstream word stream plus send/feedback pair to the synchronizer
// Rev 1.0
// ============================================================================
interface mux_fdbk_src_tx_if #(
   parameter int DWIDTH = 4
);
   logic [DWIDTH-1:0] i_data;
   logic              i_valid;
   logic              o_ready;
   logic [DWIDTH-1:0] o_src_data;
   logic              o_src_valid;
   logic              i_dst_ready;

   modport slave (
      input  i_data, i_valid, i_dst_ready,
      output o_ready, o_src_data, o_src_valid
   );

   modport master (
      output i_data, i_valid, i_dst_ready,
      input  o_ready, o_src_data, o_src_valid
   );
endinterface
`default_nettype wire

// File: rtl/mux_fdbk_src_tx.sv
`default_nettype none
// ============================================================================
// mux_fdbk_src_tx : FIFO-buffered source side of a ready-feedback mux synchronizer
// Rev 1.0
// ============================================================================
module mux_fdbk_src_tx #(
   parameter int DWIDTH  = 4,
   parameter int DEPTH   = 4,
   parameter int TMO_CYC = 64
) (
   input  wire logic         i_src_clk,
   input  wire logic         rst,
   mux_fdbk_src_tx_if.slave  bus,
   output logic              o_busy,
   output logic              o_tmo,
   output logic [15:0]       o_xfer_cnt
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      WAIT_LO = 2'd2,
      WAIT_HI = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] src_data_q, src_data_d;
   logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
   logic [15:0]       xfer_cnt_q, xfer_cnt_d;

   logic full, empty, push, pop, tmo;

   // Extra pointer MSB distinguishes a full wrap from an empty FIFO
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = bus.i_valid && !full;

   always_comb begin
      state_d    = state_q;
      src_data_d = src_data_q;
      wait_cnt_d = wait_cnt_q;
      xfer_cnt_d = xfer_cnt_q;
      pop        = 1'b0;
      tmo        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && bus.i_dst_ready) begin
               state_d    = SEND;
               src_data_d = mem_q[rd_ptr_q[AW-1:0]];
               wait_cnt_d = '0;
            end
         end
         SEND: begin
            pop     = 1'b1;
            state_d = WAIT_LO;
         end
         WAIT_LO: begin
            // A ready drop wins over an expiring counter in the same cycle
            if (!bus.i_dst_ready) begin
               state_d = WAIT_HI;
            end else if (wait_cnt_q == TMO_LAST) begin
               state_d = IDLE;
               tmo     = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         WAIT_HI: begin
            if (bus.i_dst_ready) begin
               state_d    = IDLE;
               xfer_cnt_d = xfer_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   always_ff @(posedge i_src_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         src_data_q <= '0;
         wait_cnt_q <= '0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         src_data_q <= src_data_d;
         wait_cnt_q <= wait_cnt_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   always_ff @(posedge i_src_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.i_data;
      end
   end

   assign bus.o_ready     = !full;
   assign bus.o_src_valid = (state_q == SEND);
   assign bus.o_src_data  = src_data_q;
   assign o_busy          = (state_q != IDLE);
   assign o_tmo           = tmo;
   assign o_xfer_cnt      = xfer_cnt_q;
endmodule
`default_nettype wire
